// File: rtl/ibex_rf_write_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ibex_rf_write_buffer_if                                              |
// | Writeback / register-file / forwarding signal bundle for the buffer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ibex_rf_write_buffer_if #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
);
    logic                         wb_we_i;
    logic [4:0]                   wb_waddr_i;
    logic [DataWidth-1:0]         wb_wdata_i;
    logic                         wb_ready_o;
    logic                         rf_we_o;
    logic [4:0]                   rf_waddr_o;
    logic [DataWidth-1:0]         rf_wdata_o;
    logic                         rf_stall_i;
    logic [4:0]                   raddr_a_i;
    logic [4:0]                   raddr_b_i;
    logic                         fwd_a_valid_o;
    logic [DataWidth-1:0]         fwd_a_data_o;
    logic                         fwd_b_valid_o;
    logic [DataWidth-1:0]         fwd_b_data_o;
    logic                         full_o;
    logic                         empty_o;
    logic [$clog2(Depth):0]       level_o;

    modport slave (
        input  wb_we_i, wb_waddr_i, wb_wdata_i, rf_stall_i, raddr_a_i, raddr_b_i,
        output wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output fwd_a_valid_o, fwd_a_data_o, fwd_b_valid_o, fwd_b_data_o,
        output full_o, empty_o, level_o
    );

    modport master (
        output wb_we_i, wb_waddr_i, wb_wdata_i, rf_stall_i, raddr_a_i, raddr_b_i,
        input  wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  fwd_a_valid_o, fwd_a_data_o, fwd_b_valid_o, fwd_b_data_o,
        input  full_o, empty_o, level_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_rf_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ibex_rf_write_buffer                                                 |
// | FIFO of pending register writes in front of RF port W1, with bypass  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ibex_rf_write_buffer #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4,
    parameter bit RV32E     = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ibex_rf_write_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(Depth);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0]     wp;
    logic [PTR_W-1:0]     rp;
    logic [LVL_W-1:0]     level;
    logic [Depth-1:0]     valid;
    logic [4:0]           addr_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];

    logic                 empty;
    logic                 full;
    logic                 addr_ok;
    logic                 enq;
    logic                 pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(Depth));
    // x0 and (on RV32E) x16..x31 are acknowledged but silently dropped
    assign addr_ok = (bus.wb_waddr_i != 5'd0) && !(RV32E && bus.wb_waddr_i[4]);
    assign enq     = bus.wb_we_i && !full && addr_ok;
    assign pop     = !empty && !bus.rf_stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            valid <= '0;
        end else begin
            if (enq) begin
                valid[wp] <= 1'b1;
                wp        <= wp + 1'b1;
            end
            if (pop) begin
                valid[rp] <= 1'b0;
                rp        <= rp + 1'b1;
            end
            case ({enq, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) begin
            addr_q[wp] <= bus.wb_waddr_i;
            data_q[wp] <= bus.wb_wdata_i;
        end
    end

    assign bus.wb_ready_o = !full;
    assign bus.rf_we_o    = !empty;
    assign bus.rf_waddr_o = empty ? 5'd0 : addr_q[rp];
    assign bus.rf_wdata_o = empty ? '0 : data_q[rp];
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.level_o    = level;

    logic [PTR_W-1:0]     idx;
    logic                 hit_a;
    logic                 hit_b;
    logic [DataWidth-1:0] val_a;
    logic [DataWidth-1:0] val_b;

    // Scan oldest to youngest so the last match is the youngest entry
    always_comb begin
        idx   = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        val_a = '0;
        val_b = '0;
        for (int k = 0; k < Depth; k++) begin
            idx = rp + PTR_W'(k);
            if (valid[idx] && (bus.raddr_a_i != 5'd0) && (addr_q[idx] == bus.raddr_a_i)) begin
                hit_a = 1'b1;
                val_a = data_q[idx];
            end
            if (valid[idx] && (bus.raddr_b_i != 5'd0) && (addr_q[idx] == bus.raddr_b_i)) begin
                hit_b = 1'b1;
                val_b = data_q[idx];
            end
        end
    end

    assign bus.fwd_a_valid_o = hit_a;
    assign bus.fwd_a_data_o  = val_a;
    assign bus.fwd_b_valid_o = hit_b;
    assign bus.fwd_b_data_o  = val_b;
endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ibex_rf_write_buffer                                              |
// | Directed bench: main instance (RV32E=0) plus an RV32E=1 instance     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ibex_rf_write_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ibex_rf_write_buffer_if #(.DataWidth(32), .Depth(4)) bus   ();
    ibex_rf_write_buffer_if #(.DataWidth(32), .Depth(4)) bus_e ();

    ibex_rf_write_buffer #(.DataWidth(32), .Depth(4), .RV32E(1'b0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    ibex_rf_write_buffer #(.DataWidth(32), .Depth(4), .RV32E(1'b1)) dut_e (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_e.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i    = 1'b1;
        bus.wb_waddr_i = a;
        bus.wb_wdata_i = d;
        tick();
        bus.wb_we_i    = 1'b0;
    endtask

    initial begin
        bus.wb_we_i = 1'b0;   bus.wb_waddr_i = '0;  bus.wb_wdata_i = '0;
        bus.rf_stall_i = 1'b0; bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd7;
        bus_e.wb_we_i = 1'b0; bus_e.wb_waddr_i = '0; bus_e.wb_wdata_i = '0;
        bus_e.rf_stall_i = 1'b0; bus_e.raddr_a_i = '0; bus_e.raddr_b_i = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", bus.wb_ready_o, 1);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_rf_we", bus.rf_we_o, 0);
        chk("rst_rf_waddr", bus.rf_waddr_o, 0);
        chk("rst_rf_wdata", bus.rf_wdata_o, 0);
        chk("rst_fwd_a", {bus.fwd_a_valid_o, bus.fwd_a_data_o}, 0);
        chk("rst_fwd_b", {bus.fwd_b_valid_o, bus.fwd_b_data_o}, 0);

        // Single write, 1-cycle latency, forwarding while pending
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd5; bus.wb_wdata_i = 32'hDEADBEEF;
        #1;
        chk("same_cycle_no_fwd", bus.fwd_a_valid_o, 0);
        tick();
        bus.wb_we_i = 1'b0;
        #1;
        chk("single_rf_we", bus.rf_we_o, 1);
        chk("single_rf_waddr", bus.rf_waddr_o, 5);
        chk("single_rf_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        chk("single_level", bus.level_o, 1);
        chk("single_fwd_a_valid", bus.fwd_a_valid_o, 1);
        chk("single_fwd_a_data", bus.fwd_a_data_o, 32'hDEADBEEF);
        tick();
        chk("single_empty_after", bus.empty_o, 1);
        chk("single_fwd_gone", bus.fwd_a_valid_o, 0);

        // Fill under stall, refuse fifth push, drain in order
        bus.rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
        #1;
        chk("fill_full", bus.full_o, 1);
        chk("fill_ready", bus.wb_ready_o, 0);
        chk("fill_level", bus.level_o, 4);
        bus.raddr_a_i = 5'd9;
        push(5'd9, 32'h99);
        #1;
        chk("fifth_level", bus.level_o, 4);
        chk("fifth_not_fwd", bus.fwd_a_valid_o, 0);
        chk("stall_head", bus.rf_waddr_o, 1);
        bus.rf_stall_i = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_addr", bus.rf_waddr_o, 64'(i));
            chk("drain_data", bus.rf_wdata_o, 64'(i * 'h11));
            tick();
            if (i == 1) chk("ready_after_retire", bus.wb_ready_o, 1);
        end
        chk("drain_empty", bus.empty_o, 1);

        // Youngest-wins forwarding
        bus.rf_stall_i = 1'b1;
        bus.raddr_b_i  = 5'd7;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        #1;
        chk("yw_level", bus.level_o, 2);
        chk("yw_fwd_b", {bus.fwd_b_valid_o, bus.fwd_b_data_o}, {1'b1, 32'hB});
        bus.rf_stall_i = 1'b0;
        #1;
        chk("yw_head_data", bus.rf_wdata_o, 32'hA);
        tick();
        chk("yw_after1", {bus.fwd_b_valid_o, bus.fwd_b_data_o}, {1'b1, 32'hB});
        chk("yw_after1_head", bus.rf_wdata_o, 32'hB);
        tick();
        chk("yw_after2", {bus.fwd_b_valid_o, bus.fwd_b_data_o}, 0);
        chk("yw_empty", bus.empty_o, 1);

        // x0 drop on both, x20 drop only on the RV32E instance
        bus.raddr_a_i = 5'd0;
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 32'hFFFF;
        bus_e.wb_we_i = 1'b1; bus_e.wb_waddr_i = 5'd20; bus_e.wb_wdata_i = 32'h1234;
        #1;
        chk("x0_ready", bus.wb_ready_o, 1);
        chk("e_x20_ready", bus_e.wb_ready_o, 1);
        tick();
        bus.wb_waddr_i = 5'd20; bus.wb_wdata_i = 32'h1234;
        bus_e.wb_waddr_i = 5'd15; bus_e.wb_wdata_i = 32'h15;
        #1;
        chk("x0_level", bus.level_o, 0);
        chk("e_x20_level", bus_e.level_o, 0);
        tick();
        bus.wb_we_i = 1'b0; bus_e.wb_we_i = 1'b0;
        #1;
        chk("x20_kept_rv32i", bus.level_o, 1);
        chk("x20_head", bus.rf_waddr_o, 20);
        chk("raddr0_no_fwd", bus.fwd_a_valid_o, 0);
        chk("e_x15_kept", bus_e.level_o, 1);
        chk("e_x15_head", bus_e.rf_waddr_o, 15);
        tick();
        chk("drop_drained", bus.empty_o, 1);
        chk("e_drained", bus_e.empty_o, 1);

        // Simultaneous push/pop at level 2 across two pointer wraps
        bus.rf_stall_i = 1'b1;
        push(5'd1, 32'h100);
        push(5'd2, 32'h101);
        bus.rf_stall_i = 1'b0;
        for (int j = 0; j < 8; j++) begin
            bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'(3 + j); bus.wb_wdata_i = 32'(32'h102 + j);
            #1;
            chk("pp_level", bus.level_o, 2);
            chk("pp_addr", bus.rf_waddr_o, 64'(1 + j));
            chk("pp_data", bus.rf_wdata_o, 64'(32'h100 + j));
            tick();
        end
        bus.wb_we_i = 1'b0;
        #1;
        chk("pp_tail1", {bus.level_o, bus.rf_waddr_o, bus.rf_wdata_o}, {3'd2, 5'd9, 32'h108});
        tick();
        chk("pp_tail2", {bus.level_o, bus.rf_waddr_o, bus.rf_wdata_o}, {3'd1, 5'd10, 32'h109});
        tick();
        chk("pp_empty", bus.empty_o, 1);

        // Reset with three writes pending; push/pop in the reset cycle ignored
        bus.rf_stall_i = 1'b1;
        push(5'd11, 32'hB11);
        push(5'd12, 32'hB12);
        push(5'd13, 32'hB13);
        #1;
        chk("mid_level", bus.level_o, 3);
        bus.raddr_a_i = 5'd11; bus.raddr_b_i = 5'd13;
        rst = 1'b1; bus.rf_stall_i = 1'b0;
        bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd14; bus.wb_wdata_i = 32'hB14;
        tick();
        rst = 1'b0; bus.wb_we_i = 1'b0;
        #1;
        chk("mid_rst_empty", bus.empty_o, 1);
        chk("mid_rst_level", bus.level_o, 0);
        chk("mid_rst_rf_we", bus.rf_we_o, 0);
        chk("mid_rst_fwd_a", bus.fwd_a_valid_o, 0);
        chk("mid_rst_fwd_b", bus.fwd_b_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_never_issued", bus.rf_we_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ibex_rf_write_buffer.md
# ibex_rf_write_buffer

Write-back buffer placed directly upstream of the register file write port W1. It accepts register writes from the writeback stage and queues them in a FIFO of `Depth` entries. It drains one entry per cycle into the register file whenever the file is not stalling its write path. While a write sits in the queue, the block forwards the youngest pending value for either read address, so the register file's write-side stalls never expose stale operands.

## Interface
Parameters:
- `DataWidth`, 32: width of register data.
- `Depth`, 4: number of FIFO entries. Must be a power of two and at least 2.
- `RV32E`, 0: when 1, only addresses 0–15 are valid.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `wb_we_i`, in, 1: write request from writeback.
- `wb_waddr_i`, in, 5: destination register.
- `wb_wdata_i`, in, `DataWidth`: write data.
- `wb_ready_o`, out, 1: buffer can accept a write this cycle.
- `rf_we_o`, out, 1: write enable to register file W1.
- `rf_waddr_o`, out, 5: head entry address.
- `rf_wdata_o`, out, `DataWidth`: head entry data.
- `rf_stall_i`, in, 1: register file cannot take the write this cycle.
- `raddr_a_i`, in, 5: read port A address. `raddr_b_i`, in, 5: read port B address.
- `fwd_a_valid_o`, out, 1: port A hits a pending entry. `fwd_a_data_o`, out, `DataWidth`: data for that hit.
- `fwd_b_valid_o`, out, 1 and `fwd_b_data_o`, out, `DataWidth`: same for port B.
- `full_o`, out, 1: all entries occupied. `empty_o`, out, 1: no entries occupied.
- `level_o`, out, $clog2(Depth)+1: current occupancy.

## Operation
- Storage: `Depth` entries, each holding {valid, addr[4:0], data}. Write pointer `wp` and read pointer `rp` are $clog2(Depth) bits wide and wrap modulo `Depth`. `level` runs 0..`Depth`.
- Push:
  - A push fires when `wb_we_i && wb_ready_o`.
  - Writes to x0, and writes to addresses ≥16 when `RV32E=1`, are accepted and discarded: no enqueue, no level change.
  - Otherwise the entry is written at `wp` and `wp` increments.
- Pop:
  - `rf_we_o = !empty_o`.
  - The entry at `rp` is retired on the edge where `rf_we_o && !rf_stall_i`. Retiring clears its valid bit and increments `rp`.
- Simultaneous push and pop: both pointers advance and `level` is unchanged.
- `wb_ready_o = !full_o`. It depends only on registered state and has no combinational path from `rf_stall_i`. A push is refused when full, even if a pop occurs in the same cycle.
- `rf_waddr_o` and `rf_wdata_o` show the head entry when non-empty and are forced to 0 when empty.
- Forwarding, per port, purely combinational:
  - The port compares its read address against all valid entries, including the head being retired this cycle.
  - Address 0 never matches.
  - On multiple matches the youngest entry (closest to `wp`) wins.
  - `fwd_x_data_o` is 0 when `fwd_x_valid_o` is 0.
  - A write being pushed in the same cycle is not forwarded.
- Ordering: writes reach the register file in acceptance order. Writes to the same register are never merged.
- Flags: `full_o = (level == Depth)`, `empty_o = (level == 0)`, `level_o = level`. All are registered-state derived.

## Timing
- Reset: on a posedge with `rst_i=1`, the block clears `wp`, `rp`, `level` and all valid bits. Data fields need not reset. Outputs in the first cycle after reset:
  - `wb_ready_o=1`, `empty_o=1`, `full_o=0`, `level_o=0`.
  - `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`.
  - `fwd_*_valid_o=0`, `fwd_*_data_o=0`.
- Reset mid-operation discards all pending writes, and push/pop in that cycle are ignored.
- Latency: a write accepted at edge N drives `rf_we_o` in the cycle after edge N, provided the queue was empty. Minimum push-to-register-file latency is 1 cycle. Throughput is 1 write per cycle when `rf_stall_i=0`.
- Forwarding: valid from the cycle after the push edge until the cycle containing the retiring edge, inclusive.
- Full: with `Depth` entries held and `rf_stall_i` high, `wb_ready_o` stays 0. It returns to 1 in the cycle after the first retire.

## Test plan
- Reset, then single write: push x5=0xDEADBEEF at edge 1.
  - Cycle 2: `rf_we_o=1`, `rf_waddr_o=5`, `level_o=1`.
  - Cycle 2 with `raddr_a_i=5`: `fwd_a_valid_o=1`, `fwd_a_data_o=0xDEADBEEF`.
  - Cycle 3: `empty_o=1`.
- Fill under stall: hold `rf_stall_i=1` and push x1..x4 with data 0x11..0x44.
  - `full_o=1` and `wb_ready_o=0`.
  - A fifth push is refused.
  - Release the stall: writes drain in order x1, x2, x3, x4, one per cycle.
- Youngest-wins forwarding: push x7=0xA, then x7=0xB, under stall.
  - `raddr_b_i=7` yields 0xB.
  - After the first retire it still yields 0xB.
  - After the second retire, `fwd_b_valid_o=0`.
- x0 and RV32E drop: push x0=0xFFFF; with `RV32E=1`, push x20=0x1234.
  - Both are accepted (`wb_ready_o=1`) and `level_o` stays 0.
  - `raddr_a_i=0` never forwards.
- Simultaneous push/pop at `level=2` with `rf_stall_i=0`: `level_o` stays 2. Run 2×`Depth` pushes so both pointers wrap, and check order is preserved.
- Reset mid-operation: with 3 entries pending, assert `rst_i` for one edge.
  - The following cycle: `empty_o=1`, `rf_we_o=0`, `fwd_*_valid_o=0`.
  - The pending writes are never issued to the register file.
